// File: rtl/uart_prog_loader_pkg.sv
// Shared constants, FSM state encodings and address helper for the UART program loader.
package uart_prog_loader_pkg;

  // Boot address of instruction word 0 and instruction memory depth (words).
  localparam logic [31:0] ENTRY_DEFAULT        = 32'h8000_0000;
  localparam int          MEM_WORDS_DEFAULT    = 2056;
  // 50 MHz system clock, 115200 baud.
  localparam int          CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_LEN,
    LD_DATA,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  // Byte address of a word index relative to the image base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port plus loader status, as seen by the core side.
interface uart_prog_loader_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  // Loader drives everything.
  modport master (
    output mem_we, mem_addr, mem_wdata, cpu_hold, done, err, words_loaded
  );

  // Memory / core / status consumers.
  modport slave (
    input mem_we, mem_addr, mem_wdata, cpu_hold, done, err, words_loaded
  );
endinterface

// File: rtl/uart_prog_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid / frame_err pulses.
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_async,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta_reg;
  logic          rx_sync_reg;
  rx_state_t     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          byte_valid_reg;
  logic [7:0]    byte_data_reg;
  logic          frame_err_reg;

  // Bring the asynchronous line into the clk domain; idle level is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_async;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Receive FSM: confirm start at half bit, then sample each full bit period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RX_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
      byte_data_reg  <= '0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          cnt_reg <= '0;
          if (!rx_sync_reg) state_reg <= RX_START;
        end
        RX_START: begin
          if (cnt_reg == HALF) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            // A line back at 1 means a glitch, not a start bit.
            state_reg   <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_sync_reg, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) state_reg <= RX_STOP;
            else bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            state_reg <= RX_IDLE;
            if (rx_sync_reg) begin
              byte_valid_reg <= 1'b1;
              byte_data_reg  <= shift_reg;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = byte_valid_reg;
  assign byte_data  = byte_data_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a length-prefixed little-endian image and
// writes it into instruction memory, holding the core in reset until done.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int          MEM_WORDS    = MEM_WORDS_DEFAULT,
  parameter logic [31:0] ENTRY        = ENTRY_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ser_rx,
  uart_prog_loader_if.master  bus
);

  localparam logic [31:0] MAX_LEN = 32'(MEM_WORDS);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  ld_state_t   state_reg;
  logic [31:0] len_reg;
  logic [31:0] word_reg;
  logic [1:0]  byte_cnt_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic        cpu_hold_reg;
  logic        done_reg;
  logic        err_reg;
  logic [15:0] words_loaded_reg;

  logic [31:0] len_next;
  logic [31:0] word_next;
  logic        last_word;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_async   (ser_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // Little-endian assembly: each new byte enters at the top and shifts down.
  assign len_next  = {byte_data, len_reg[31:8]};
  assign word_next = {byte_data, word_reg[31:8]};
  assign last_word = ({16'd0, words_loaded_reg} + 32'd1) == len_reg;

  // Loader FSM with registered memory strobe and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= LD_LEN;
      len_reg          <= '0;
      word_reg         <= '0;
      byte_cnt_reg     <= '0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= ENTRY;
      mem_wdata_reg    <= '0;
      cpu_hold_reg     <= 1'b1;
      done_reg         <= 1'b0;
      err_reg          <= 1'b0;
      words_loaded_reg <= '0;
    end else begin
      mem_we_reg <= 1'b0;
      // Count advances in the cycle following each strobe.
      if (mem_we_reg) words_loaded_reg <= words_loaded_reg + 16'd1;
      case (state_reg)
        LD_LEN: begin
          if (frame_err) begin
            err_reg   <= 1'b1;
            state_reg <= LD_ERR;
          end else if (byte_valid) begin
            len_reg      <= len_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              if (len_next == 32'd0) begin
                state_reg    <= LD_DONE;
                done_reg     <= 1'b1;
                cpu_hold_reg <= 1'b0;
              end else if (len_next > MAX_LEN) begin
                err_reg   <= 1'b1;
                state_reg <= LD_ERR;
              end else begin
                state_reg <= LD_DATA;
              end
            end
          end
        end
        LD_DATA: begin
          if (frame_err) begin
            // Partial word is simply abandoned.
            err_reg   <= 1'b1;
            state_reg <= LD_ERR;
          end else begin
            if (byte_valid) begin
              word_reg     <= word_next;
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
              if (byte_cnt_reg == 2'd3) begin
                mem_we_reg    <= 1'b1;
                mem_wdata_reg <= word_next;
                mem_addr_reg  <= word_addr(ENTRY, words_loaded_reg);
              end
            end
            if (mem_we_reg && last_word) begin
              state_reg    <= LD_DONE;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
            end
          end
        end
        LD_DONE: begin
          done_reg     <= 1'b1;
          cpu_hold_reg <= 1'b0;
        end
        LD_ERR: begin
          cpu_hold_reg <= 1'b1;
        end
        default: state_reg <= LD_ERR;
      endcase
    end
  end

  assign bus.mem_we       = mem_we_reg;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_wdata    = mem_wdata_reg;
  assign bus.cpu_hold     = cpu_hold_reg;
  assign bus.done         = done_reg;
  assign bus.err          = err_reg;
  assign bus.words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed testbench for uart_prog_loader with a write scoreboard.
module tb_uart_prog_loader;

  localparam int          CPB   = 8;
  localparam int          MEMW  = 16;
  localparam logic [31:0] ENTRY = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_rx = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];

  uart_prog_loader_if bus();

  uart_prog_loader #(
    .CLKS_PER_BIT (CPB),
    .MEM_WORDS    (MEMW),
    .ENTRY        (ENTRY)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ser_rx (ser_rx),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every write strobe is matched against the next expected write.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      logic [63:0] e;
      n_checks++;
      if (prev_we) begin
        n_fail++;
        $display("FAIL we_back_to_back: got 2 consecutive strobes expected 1");
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.mem_addr !== e[63:32] || bus.mem_wdata !== e[31:0]) begin
          n_fail++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   bus.mem_addr, bus.mem_wdata, e[63:32], e[31:0]);
        end else begin
          $display("ok   write: addr %h data %h", bus.mem_addr, bus.mem_wdata);
        end
      end
    end
    prev_we = (bus.mem_we === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    ser_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    ser_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(t[7:0], 1'b1);
    end
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},    32'(bus.mem_we), 32'd0);
    check({tag, "_addr"},  bus.mem_addr, ENTRY);
    check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_hold"},  32'(bus.cpu_hold), 32'd1);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_err"},   32'(bus.err), 32'd0);
    check({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
  endtask

  task automatic check_status(input string tag, input int words, input logic d,
                              input logic h, input logic e);
    check({tag, "_words"}, 32'(bus.words_loaded), 32'(words));
    check({tag, "_done"},  32'(bus.done), 32'(d));
    check({tag, "_hold"},  32'(bus.cpu_hold), 32'(h));
    check({tag, "_err"},   32'(bus.err), 32'(e));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_reset_state("rst");

    // Two-word image
    expect_write(32'h8000_0000, 32'h0000_0013);
    expect_write(32'h8000_0004, 32'h0000_006F);
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    repeat (4) @(negedge clk);
    check_status("img2", 2, 1'b1, 1'b0, 1'b0);
    // Further bytes after completion are ignored
    send_word(32'h1234_5678);
    check_status("img2_after", 2, 1'b1, 1'b0, 1'b0);

    // Zero-length image
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("len0_partial_done", 32'(bus.done), 32'd0);
    send_byte(8'h00, 1'b1);
    check_status("len0", 0, 1'b1, 1'b0, 1'b0);

    // Length too large (17 > 16)
    do_reset();
    send_word(32'd17);
    check_status("len17", 0, 1'b0, 1'b1, 1'b1);
    send_word(32'hCAFE_F00D);
    check_status("len17_data", 0, 1'b0, 1'b1, 1'b1);

    // Framing error on first data byte
    do_reset();
    send_word(32'd1);
    send_byte(8'h55, 1'b0);
    check_status("ferr", 0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check_status("ferr_stuck", 0, 1'b0, 1'b1, 1'b1);
    do_reset();
    check_reset_state("ferr_rst");
    expect_write(32'h8000_0000, 32'h4433_2211);
    send_word(32'd1);
    send_word(32'h4433_2211);
    repeat (4) @(negedge clk);
    check_status("ferr_reload", 1, 1'b1, 1'b0, 1'b0);

    // Short glitch on idle line, then a valid one-word image
    do_reset();
    ser_rx = 1'b0;
    repeat (2) @(negedge clk);
    ser_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_err", 32'(bus.err), 32'd0);
    expect_write(32'h8000_0000, 32'hDDCC_BBAA);
    send_word(32'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    repeat (4) @(negedge clk);
    check_status("glitch", 1, 1'b1, 1'b0, 1'b0);

    // Reset partway through a word, then a fresh image
    do_reset();
    send_word(32'd1);
    send_byte(8'hEE, 1'b1);
    send_byte(8'hFF, 1'b1);
    do_reset();
    check_reset_state("midrst");
    expect_write(32'h8000_0000, 32'h0403_0201);
    send_word(32'd1);
    send_word(32'h0403_0201);
    repeat (4) @(negedge clk);
    check_status("midrst_reload", 1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream of the riscv_i core. Receives a program image over the board UART (ser_rx, 8N1) and writes it word-by-word into instruction memory starting at ENTRY.
- Holds the core in reset until the image is complete, then releases it so fetch starts at ENTRY.
- Replaces the simulation-only $readmemh load path on the DE10-Lite.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- MEM_WORDS, 2056, instruction memory depth in 32-bit words.
- ENTRY, 32'h8000_0000, byte address of word 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ser_rx  in  1  asynchronous UART line, idle high
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  32  byte address of the word being written (ENTRY + 4*index)
- mem_wdata  out  32  assembled little-endian word
- cpu_hold  out  1  high while loading; drives the core reset
- done  out  1  image fully written, sticky
- err  out  1  framing or length error, sticky
- words_loaded  out  16  count of words written so far

Behaviour:
- Reset values: mem_we=0, mem_addr=ENTRY, mem_wdata=0, cpu_hold=1, done=0, err=0, words_loaded=0. The synchronizer flops reset to 1. Reset mid-frame aborts everything and returns to RX_IDLE/LD_LEN.
- Synchronizer: 2 flops on ser_rx; the UART RX FSM uses only the synchronized value.
- UART RX FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - RX_IDLE: on synchronized line = 0, go to RX_START with counter cleared.
  - RX_START: at count CLKS_PER_BIT/2 (integer division), re-sample. If the line is 1 it is a false start; return to RX_IDLE with no error. Otherwise go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT. If the line is 1, emit byte_valid (1 cycle) with the byte. If the line is 0, emit frame_err (1 cycle) and no byte. Either way, return to RX_IDLE.
- Loader FSM, states LD_LEN, LD_DATA, LD_DONE, LD_ERR:
  - LD_LEN: collect 4 bytes little-endian into len (word count).
    - After the 4th byte: len == 0 goes to LD_DONE; len > MEM_WORDS sets err and goes to LD_ERR; otherwise go to LD_DATA.
  - LD_DATA: shift bytes into the word little-endian (first byte = bits 7:0).
    - On the 4th byte of a word, assert mem_we in the next cycle with mem_wdata = word and mem_addr = ENTRY + 4*words_loaded.
    - In the cycle after the strobe, words_loaded increments.
    - When words_loaded reaches len, go to LD_DONE.
  - LD_DONE: done=1 and cpu_hold=0 from the cycle after entry. All further bytes are ignored; no writes.
  - LD_ERR: cpu_hold stays 1, no writes, bytes ignored. Only reset exits.
- frame_err in LD_LEN or LD_DATA sets err and goes to LD_ERR; any partial word is discarded. A frame_err in LD_DONE is ignored.
- Latency: mem_we rises exactly 1 clk after byte_valid of the 4th word byte. byte_valid occurs at the stop-bit sample, about 9.5 bit times after the start-bit falling edge, plus 2 synchronizer cycles.
- mem_we is never asserted for two consecutive cycles. A byte cannot arrive faster than 10*CLKS_PER_BIT cycles, so there is no backpressure and no buffering.
- Word index wrap is impossible because len <= MEM_WORDS is enforced.

Decomposition:
- Shared include riscv_defs.vh: ENTRY, MEM_WORDS, the default CLKS_PER_BIT, and the localparam encodings of both FSMs' states. riscv_i uses the same ENTRY/MEM_WORDS.
- Sub-module uart_rx (clk, reset, rx_async -> byte_valid, byte_data, frame_err), parameter CLKS_PER_BIT. It contains the synchronizer and the RX FSM. The loader FSM is in uart_prog_loader.

Test Plan (CLKS_PER_BIT=8, MEM_WORDS=16):
- Send len bytes 02 00 00 00, then 13 00 00 00 and 6F 00 00 00.
  - Response: mem_we pulses twice, (addr 8000_0000, data 0000_0013) then (8000_0004, 0000_006F).
  - words_loaded=2, done=1, cpu_hold=0, err=0.
- Send len 00 00 00 00 -> no mem_we; done=1 and cpu_hold=0 one cycle after the 4th byte_valid.
- Send len 11 00 00 00 (17 > 16) -> err=1, cpu_hold=1, done=0. The following data bytes produce no mem_we.
- Send len 01 00 00 00, then one byte with stop bit driven 0 -> err=1, no mem_we, stays in LD_ERR. Reset -> all outputs return to their reset values and a fresh valid image loads correctly.
- Send a 2-cycle low glitch on idle ser_rx, then a valid image of len 1 word AA BB CC DD -> no error. Single write of data DDCC_BBAA at 8000_0000.
- Assert reset after 2 of 4 data bytes -> no write. The subsequent full image loads from word 0 at ENTRY.
